// File: rtl/timer_pkg.sv
// Register map, control bits, bus payload and FSM states shared by the interval timer master.
package timer_pkg;

    localparam logic [2:0] STATUS  = 3'd0;
    localparam logic [2:0] CONTROL = 3'd1;
    localparam logic [2:0] PERIODL = 3'd2;
    localparam logic [2:0] PERIODH = 3'd3;
    localparam logic [2:0] SNAPL   = 3'd4;
    localparam logic [2:0] SNAPH   = 3'd5;

    localparam logic [15:0] ITO   = 16'h0001;
    localparam logic [15:0] CONT  = 16'h0002;
    localparam logic [15:0] START = 16'h0004;
    localparam logic [15:0] STOP  = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_CLR,
        S_WR_STOP,
        S_SNAP_WR,
        S_SNAP_RL,
        S_SNAP_RH,
        S_SNAP_CAP
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

    function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
        return '{cs: 1'b1, write_n: 1'b0, addr: addr, wdata: data};
    endfunction

    function automatic bus_t bus_rd(input logic [2:0] addr);
        return '{cs: 1'b1, write_n: 1'b1, addr: addr, wdata: 16'd0};
    endfunction

    function automatic logic [31:0] clamp_period(input logic [31:0] req, input logic [31:0] min_p);
        return (req < min_p) ? min_p : req;
    endfunction

endpackage

// File: rtl/timer_tick_master.sv
// Avalon-MM master that programs the interval timer, services its timeouts into ticks
// and captures counter snapshots on request.
module timer_tick_master
    import timer_pkg::*;
#(
    parameter int unsigned TICK_W     = 32,
    parameter int unsigned MIN_PERIOD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_load,
    input  logic              snap_req,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic              busy
);

    state_t              state_q;
    bus_t                bus_q;
    logic [31:0]         period_m1_q;
    logic                enable_q;
    logic                snap_pend_q;
    logic [15:0]         snap_lo_q;
    logic                tick_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    logic [31:0]         snap_val_q;
    logic                snap_valid_q;
    logic                busy_q;

    // Timer reload value: one timeout every max(cfg_period, MIN_PERIOD) clocks.
    logic [31:0] period_m1_d;
    assign period_m1_d = clamp_period(cfg_period, 32'(MIN_PERIOD)) - 32'd1;

    logic enable_rise;
    assign enable_rise = enable & ~enable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bus_q        <= BUS_IDLE;
            period_m1_q  <= 32'd0;
            enable_q     <= 1'b0;
            snap_pend_q  <= 1'b0;
            snap_lo_q    <= 16'd0;
            tick_q       <= 1'b0;
            tick_cnt_q   <= '0;
            snap_val_q   <= 32'd0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            enable_q     <= enable;
            tick_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            bus_q        <= BUS_IDLE;
            busy_q       <= 1'b0;
            // Requests merge into one pending snapshot until RUN takes it.
            snap_pend_q  <= snap_pend_q | snap_req;

            case (state_q)
                S_IDLE: begin
                    if (enable_rise) begin
                        period_m1_q <= period_m1_d;
                        bus_q       <= bus_wr(PERIODL, period_m1_d[15:0]);
                        busy_q      <= 1'b1;
                        state_q     <= S_WR_PL;
                    end
                end
                S_WR_PL: begin
                    bus_q   <= bus_wr(PERIODH, period_m1_q[31:16]);
                    busy_q  <= 1'b1;
                    state_q <= S_WR_PH;
                end
                S_WR_PH: begin
                    // START outranks the stop implied by the period writes.
                    bus_q   <= bus_wr(CONTROL, START | CONT | ITO);
                    busy_q  <= 1'b1;
                    state_q <= S_WR_CTRL;
                end
                S_WR_CTRL: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (!enable) begin
                        bus_q   <= bus_wr(CONTROL, STOP);
                        busy_q  <= 1'b1;
                        state_q <= S_WR_STOP;
                    end else if (tmr_irq) begin
                        bus_q   <= bus_wr(STATUS, 16'd0);
                        busy_q  <= 1'b1;
                        state_q <= S_CLR;
                    end else if (cfg_load) begin
                        period_m1_q <= period_m1_d;
                        bus_q       <= bus_wr(PERIODL, period_m1_d[15:0]);
                        busy_q      <= 1'b1;
                        state_q     <= S_WR_PL;
                    end else if (snap_pend_q) begin
                        snap_pend_q <= snap_req;
                        bus_q       <= bus_wr(SNAPL, 16'd0);
                        busy_q      <= 1'b1;
                        state_q     <= S_SNAP_WR;
                    end
                end
                S_CLR: begin
                    tick_q     <= 1'b1;
                    tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    state_q    <= S_RUN;
                end
                S_WR_STOP: begin
                    state_q <= S_IDLE;
                end
                S_SNAP_WR: begin
                    bus_q   <= bus_rd(SNAPL);
                    busy_q  <= 1'b1;
                    state_q <= S_SNAP_RL;
                end
                S_SNAP_RL: begin
                    bus_q   <= bus_rd(SNAPH);
                    busy_q  <= 1'b1;
                    state_q <= S_SNAP_RH;
                end
                S_SNAP_RH: begin
                    // Read data trails its address by one cycle.
                    snap_lo_q <= tmr_readdata;
                    busy_q    <= 1'b1;
                    state_q   <= S_SNAP_CAP;
                end
                S_SNAP_CAP: begin
                    snap_val_q   <= {tmr_readdata, snap_lo_q};
                    snap_valid_q <= 1'b1;
                    state_q      <= S_RUN;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tmr_address    = bus_q.addr;
    assign tmr_chipselect = bus_q.cs;
    assign tmr_write_n    = bus_q.write_n;
    assign tmr_writedata  = bus_q.wdata;
    assign tick           = tick_q;
    assign tick_count     = tick_cnt_q;
    assign snap_value     = snap_val_q;
    assign snap_valid     = snap_valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_timer_tick_master.sv
// Bench for timer_tick_master: a behavioural interval timer slave, programming vectors,
// corner-case sequences and a randomized run checked against the timer model's event counts.
module tb_timer_tick_master;

    localparam int unsigned TICK_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [31:0]       cfg_period;
    logic              cfg_load;
    logic              snap_req;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic [15:0]       tmr_readdata;
    logic              tmr_irq;
    logic              tick;
    logic [TICK_W-1:0] tick_count;
    logic [31:0]       snap_value;
    logic              snap_valid;
    logic              busy;

    always #5 clk = ~clk;

    timer_tick_master #(.TICK_W(TICK_W), .MIN_PERIOD(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .cfg_period     (cfg_period),
        .cfg_load       (cfg_load),
        .snap_req       (snap_req),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq),
        .tick           (tick),
        .tick_count     (tick_count),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
        .busy           (busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural interval timer slave ----------------
    logic [15:0] m_pl, m_ph, m_rdata;
    logic [31:0] m_cnt, m_snap, snap_src;
    logic        m_run, m_to, inj_irq;
    int          m_timeouts, m_lost, m_clr_writes;
    logic        m_wr, m_rd, m_tmo;

    assign m_wr         = tmr_chipselect && !tmr_write_n;
    assign m_rd         = tmr_chipselect && tmr_write_n;
    assign m_tmo        = m_run && (m_cnt == 32'd0);
    assign tmr_irq      = m_to | inj_irq;
    assign tmr_readdata = m_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pl <= 16'd0; m_ph <= 16'd0; m_cnt <= 32'd0; m_run <= 1'b0; m_to <= 1'b0;
            m_snap <= 32'd0; m_rdata <= 16'd0;
            m_timeouts <= 0; m_lost <= 0; m_clr_writes <= 0;
        end else begin
            if (m_wr && tmr_address == 3'd2) m_pl <= tmr_writedata;
            if (m_wr && tmr_address == 3'd3) m_ph <= tmr_writedata;
            if (m_wr && tmr_address == 3'd4) m_snap <= snap_src;
            if (m_wr && tmr_address == 3'd1 && tmr_writedata[2]) begin
                m_run <= 1'b1;
                m_cnt <= {m_ph, m_pl};
            end else if (m_wr && tmr_address == 3'd1 && tmr_writedata[3]) begin
                m_run <= 1'b0;
            end else if (m_run) begin
                m_cnt <= m_tmo ? {m_ph, m_pl} : m_cnt - 32'd1;
            end
            if (m_wr && tmr_address == 3'd0) begin
                m_to <= 1'b0;
                m_clr_writes <= m_clr_writes + 1;
            end
            if (m_tmo) begin
                m_to <= 1'b1;
                m_timeouts <= m_timeouts + 1;
                if (m_to && !(m_wr && tmr_address == 3'd0)) m_lost <= m_lost + 1;
            end
            if (!m_rd)                      m_rdata <= 16'h0;
            else if (tmr_address == 3'd4)   m_rdata <= m_snap[15:0];
            else if (tmr_address == 3'd5)   m_rdata <= m_snap[31:16];
            else                            m_rdata <= 16'h0;
        end
    end

    // ---------------- bus / tick monitor ----------------
    typedef struct packed {
        logic [2:0]  a;
        logic        w;
        logic [15:0] d;
    } bus_rec_t;

    function automatic bus_rec_t rec(input logic [2:0] a, input logic w, input logic [15:0] d);
        return '{a: a, w: w, d: d};
    endfunction

    bus_rec_t q[$];
    int       tick_times[$];
    int       cyc = 0;
    logic     prev_clr = 1'b0;
    logic     rnd_phase = 1'b0;
    int       rnd_snaps = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tmr_chipselect)
            q.push_back(rec(tmr_address, !tmr_write_n, tmr_write_n ? 16'h0 : tmr_writedata));
        if (tick) tick_times.push_back(cyc);
        if (tick || prev_clr) chk("tick_after_clr", 64'(tick), 64'(prev_clr));
        prev_clr = tmr_chipselect && !tmr_write_n && (tmr_address == 3'd0);
        if (rnd_phase && snap_valid) begin
            chk("rnd_snap_value", 64'(snap_value), 64'(m_snap));
            rnd_snaps++;
        end
    end

    task automatic start_period(input logic [31:0] p);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        cfg_period = p;
        enable = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] period;
        logic [15:0] pl;
        logic [15:0] ph;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [31:0] tc0;
        int          lat, nclr, vcyc, ccyc, found;

        vecs[0] = '{32'd1000,       16'h03E7, 16'h0000};
        vecs[1] = '{32'd3,          16'h0007, 16'h0000};
        vecs[2] = '{32'd0,          16'h0007, 16'h0000};
        vecs[3] = '{32'd8,          16'h0007, 16'h0000};
        vecs[4] = '{32'd9,          16'h0008, 16'h0000};
        vecs[5] = '{32'h0001_2345,  16'h2344, 16'h0001};
        vecs[6] = '{32'h0001_0000,  16'hFFFF, 16'h0000};

        reset = 1'b0; enable = 1'b0; cfg_period = 32'd0; cfg_load = 1'b0;
        snap_req = 1'b0; inj_irq = 1'b0; snap_src = 32'd0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bus", 64'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
            64'({1'b0, 1'b1, 3'd0, 16'd0}));
        chk("rst_flags", 64'({tick, snap_valid, busy}), 64'd0);
        chk("rst_tick_count", 64'(tick_count), 64'd0);
        chk("rst_snap_value", 64'(snap_value), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Programming sequence per period, including clamp boundaries.
        for (int i = 0; i < 7; i++) begin
            q.delete();
            enable = 1'b0;
            repeat (4) @(negedge clk);
            if (i > 0)
                chk("stop_write", (q.size() > 0) ? 64'(q[0]) : 64'hDEAD, 64'(rec(3'd1, 1'b1, 16'h0008)));
            q.delete();
            cfg_period = vecs[i].period;
            enable = 1'b1;
            @(negedge clk);
            chk("prog_busy", 64'(busy), 64'd1);
            repeat (3) @(negedge clk);
            chk("prog_busy_done", 64'(busy), 64'd0);
            chk("prog_len", 64'(q.size()), 64'd3);
            if (q.size() >= 3) begin
                chk("prog_pl",   64'(q[0]), 64'(rec(3'd2, 1'b1, vecs[i].pl)));
                chk("prog_ph",   64'(q[1]), 64'(rec(3'd3, 1'b1, vecs[i].ph)));
                chk("prog_ctrl", 64'(q[2]), 64'(rec(3'd1, 1'b1, 16'h0007)));
            end
        end

        // Five timeouts at period 1000.
        start_period(32'd1000);
        q.delete();
        tick_times.delete();
        tc0 = tick_count;
        for (int n = 0; n < 5200 && tick_times.size() < 5; n++) @(negedge clk);
        chk("tick_n_1000", 64'(tick_times.size()), 64'd5);
        for (int i = 1; i < tick_times.size(); i++)
            chk("tick_gap_1000", 64'(tick_times[i] - tick_times[i-1]), 64'd1000);
        chk("tick_count_5", 64'(tick_count - tc0), 64'd5);
        nclr = 0;
        foreach (q[i]) if (q[i] == rec(3'd0, 1'b1, 16'h0000)) nclr++;
        chk("clr_writes_5", 64'(nclr), 64'd5);

        // Snapshot latency and bus sequence.
        repeat (5) @(negedge clk);
        q.delete();
        snap_src = 32'h0012_3456;
        snap_req = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) snap_req = 1'b0;
            if (snap_valid) lat = k;
        end
        chk("snap_latency", 64'(lat), 64'd6);
        chk("snap_value", 64'(snap_value), 64'h0012_3456);
        chk("snap_bus_len", 64'(q.size()), 64'd3);
        if (q.size() >= 3) begin
            chk("snap_bus_0", 64'({q[0].a, q[0].w}), 64'({3'd4, 1'b1}));
            chk("snap_bus_1", 64'({q[1].a, q[1].w}), 64'({3'd4, 1'b0}));
            chk("snap_bus_2", 64'({q[2].a, q[2].w}), 64'({3'd5, 1'b0}));
        end

        // irq raised while the snapshot low half is being read.
        repeat (5) @(negedge clk);
        q.delete();
        tc0 = tick_count;
        snap_src = 32'hCAFE_0042;
        snap_req = 1'b1;
        vcyc = -1;
        ccyc = -1;
        for (int k = 1; k <= 30 && ccyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) snap_req = 1'b0;
            if (tmr_chipselect && tmr_write_n && tmr_address == 3'd4) inj_irq = 1'b1;
            if (snap_valid) vcyc = k;
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
                ccyc = k;
                inj_irq = 1'b0;
            end
        end
        inj_irq = 1'b0;
        @(negedge clk);
        chk("irq_snap_tick", 64'(tick), 64'd1);
        chk("irq_clr_follows", 64'(ccyc - vcyc), 64'd1);
        chk("irq_snap_value", 64'(snap_value), 64'hCAFE_0042);
        chk("irq_tick_count", 64'(tick_count - tc0), 64'd1);
        chk("irq_bus_len", 64'(q.size()), 64'd4);
        if (q.size() >= 4) chk("irq_bus_clr", 64'(q[3]), 64'(rec(3'd0, 1'b1, 16'h0000)));

        // Clamped period: ticks 8 clocks apart.
        start_period(32'd3);
        tick_times.delete();
        for (int n = 0; n < 100 && tick_times.size() < 4; n++) @(negedge clk);
        chk("tick_n_8", 64'(tick_times.size()), 64'd4);
        for (int i = 1; i < tick_times.size(); i++)
            chk("tick_gap_8", 64'(tick_times[i] - tick_times[i-1]), 64'd8);

        // Reset while the period high half is on the bus.
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd3) found = 1;
        end
        chk("saw_wr_ph", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_bus", 64'({tmr_chipselect, tmr_write_n}), 64'({1'b0, 1'b1}));
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_tick_count", 64'(tick_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("restart_len", 64'(q.size()), 64'd3);
        if (q.size() >= 3) begin
            chk("restart_pl",   64'(q[0]), 64'(rec(3'd2, 1'b1, 16'h0007)));
            chk("restart_ph",   64'(q[1]), 64'(rec(3'd3, 1'b1, 16'h0000)));
            chk("restart_ctrl", 64'(q[2]), 64'(rec(3'd1, 1'b1, 16'h0007)));
        end

        // Randomized traffic; totals reconciled against the timer model.
        rnd_phase = 1'b1;
        for (int it = 0; it < 8000; it++) begin
            int r;
            @(negedge clk);
            cfg_load = 1'b0;
            snap_req = 1'b0;
            r = $urandom_range(0, 999);
            if (enable) begin
                if (r < 3) enable = 1'b0;
                else if (r < 12) begin
                    cfg_period = 32'($urandom_range(0, 40));
                    cfg_load = 1'b1;
                end else if (r < 40) begin
                    snap_src = $urandom;
                    snap_req = 1'b1;
                end
            end else begin
                if (r < 100) begin
                    cfg_period = 32'($urandom_range(0, 40));
                    enable = 1'b1;
                end else if (r < 110) begin
                    snap_src = $urandom;
                    snap_req = 1'b1;
                end
            end
        end
        @(negedge clk);
        cfg_load = 1'b0;
        snap_req = 1'b0;
        enable = 1'b1;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        rnd_phase = 1'b0;
        chk("rnd_lost_timeouts", 64'(m_lost), 64'd0);
        chk("rnd_tick_count", 64'(tick_count), 64'(m_timeouts - (m_to ? 1 : 0)));
        chk("rnd_clr_writes", 64'(m_clr_writes), 64'(tick_count));
        chk("rnd_snaps_seen", 64'(rnd_snaps > 0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
